// File: rtl/jtlabrun_prio.sv
// Layer priority mixer: picks one of scr0/scr1/obj or the backdrop per pixel using
// frame-shadowed CTRL/BG registers. Optional debug layer mask: JTLABRUN_LAYER_MASK_EN.
module jtlabrun_prio #(
    parameter int BLANK_DLY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pxl_cen,
    input  logic       LHBL,
    input  logic       LVBL,
    output logic       LHBL_dly,
    output logic       LVBL_dly,
    input  logic       prio_cs,
    input  logic       cpu_rnw,
    input  logic       cpu_cen,
    input  logic       cpu_addr,
    input  logic [7:0] cpu_dout,
    output logic [7:0] prio_dout,
    input  logic [6:0] scr0_pxl,
    input  logic [6:0] scr1_pxl,
    input  logic [6:0] obj_pxl,
`ifdef JTLABRUN_LAYER_MASK_EN
    input  logic [2:0] gfx_en,
`endif
    output logic [6:0] gfx_pxl,
    output logic       frame_start
);

    function automatic logic is_opaque(input logic [6:0] pxl);
        return pxl[3:0] != 4'h0;
    endfunction

    logic [7:0]           ctrl_r, bg_r, sh_ctrl_r, sh_bg_r;
    logic                 lvbl_prev_r, frame_start_r, vb_fall_s, cpu_we_s;
    logic [BLANK_DLY-1:0] hbl_sr_r, vbl_sr_r;
    logic [6:0]           scr0_s1_r, scr1_s1_r, obj_s1_r, gfx_r;
    logic [2:0]           op_s1_r, layer_en_s;
    logic [6:0]           top_s, mid_s, mix_s;
    logic                 top_op_s, mid_op_s, obj_op_s, blank_s;

`ifdef JTLABRUN_LAYER_MASK_EN
    assign layer_en_s = gfx_en;
`else
    assign layer_en_s = 3'b111;
`endif

    assign cpu_we_s  = prio_cs & ~cpu_rnw & cpu_cen;
    assign vb_fall_s = pxl_cen & lvbl_prev_r & ~LVBL;
    assign prio_dout = cpu_addr ? bg_r : ctrl_r;

    // CPU-visible live registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_r <= 8'h00;
            bg_r   <= 8'h00;
        end else if (cpu_we_s) begin
            if (cpu_addr) bg_r <= cpu_dout;
            else          ctrl_r <= cpu_dout;
        end
    end

    // LVBL fall detector; shadows sample the pre-write live values on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvbl_prev_r   <= 1'b0;
            frame_start_r <= 1'b0;
            sh_ctrl_r     <= 8'h00;
            sh_bg_r       <= 8'h00;
        end else begin
            frame_start_r <= vb_fall_s;
            if (pxl_cen) lvbl_prev_r <= LVBL;
            if (vb_fall_s) begin
                sh_ctrl_r <= ctrl_r;
                sh_bg_r   <= bg_r;
            end
        end
    end

    // Blanking delay lines, kept in step with the pixel pipeline
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hbl_sr_r <= {BLANK_DLY{1'b0}};
            vbl_sr_r <= {BLANK_DLY{1'b0}};
        end else if (pxl_cen) begin
            hbl_sr_r <= {hbl_sr_r[BLANK_DLY-2:0], LHBL};
            vbl_sr_r <= {vbl_sr_r[BLANK_DLY-2:0], LVBL};
        end
    end

    // S1: capture pixels and opacity flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr0_s1_r <= 7'h00;
            scr1_s1_r <= 7'h00;
            obj_s1_r  <= 7'h00;
            op_s1_r   <= 3'b000;
        end else if (pxl_cen) begin
            scr0_s1_r <= scr0_pxl;
            scr1_s1_r <= scr1_pxl;
            obj_s1_r  <= obj_pxl;
            op_s1_r   <= { is_opaque(obj_pxl)  & layer_en_s[2],
                           is_opaque(scr1_pxl) & layer_en_s[1],
                           is_opaque(scr0_pxl) & layer_en_s[0] };
        end
    end

    // S2 priority resolution from the shadow CTRL
    always_comb begin
        top_s    = scr0_s1_r;
        top_op_s = op_s1_r[0];
        mid_s    = scr1_s1_r;
        mid_op_s = op_s1_r[1];
        obj_op_s = op_s1_r[2] & ~sh_ctrl_r[2];
        mix_s    = {sh_bg_r[6:4], 4'h0};
        if (sh_ctrl_r[1]) begin
            top_s    = scr1_s1_r;
            top_op_s = op_s1_r[1];
            mid_s    = scr0_s1_r;
            mid_op_s = op_s1_r[0];
        end else begin
            top_s    = scr0_s1_r;
            top_op_s = op_s1_r[0];
        end
        if (!sh_ctrl_r[0]) begin
            if (obj_op_s)      mix_s = obj_s1_r;
            else if (top_op_s) mix_s = top_s;
            else if (mid_op_s) mix_s = mid_s;
            else               mix_s = {sh_bg_r[6:4], 4'h0};
        end else begin
            if (top_op_s)      mix_s = top_s;
            else if (obj_op_s) mix_s = obj_s1_r;
            else if (mid_op_s) mix_s = mid_s;
            else               mix_s = {sh_bg_r[6:4], 4'h0};
        end
        blank_s = ~(hbl_sr_r[BLANK_DLY-2] & vbl_sr_r[BLANK_DLY-2]);
    end

    // S2 output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gfx_r <= 7'h00;
        end else if (pxl_cen) begin
            gfx_r <= blank_s ? 7'h00 : mix_s;
        end
    end

    assign gfx_pxl     = gfx_r;
    assign frame_start = frame_start_r;
    assign LHBL_dly    = hbl_sr_r[BLANK_DLY-1];
    assign LVBL_dly    = vbl_sr_r[BLANK_DLY-1];

endmodule
